// File: rtl/sram_axi_responder_pkg.sv
// Shared definitions for the SRAM-like to single-beat AXI responder.
// Holds the FSM state type, AXI burst/response constants and request size codes.
// Also provides the size normalisation helper (size 3 is handled as a word).
package sram_axi_responder_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_AR   = 3'd1,
    S_RD_R    = 3'd2,
    S_WR_AW_W = 3'd3,
    S_WR_B    = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [7:0] LEN_SINGLE = 8'd0;

  localparam logic [1:0] SIZE_BYTE     = 2'd0;
  localparam logic [1:0] SIZE_HALF     = 2'd1;
  localparam logic [1:0] SIZE_WORD     = 2'd2;
  localparam logic [1:0] SIZE_WORD_ALT = 2'd3;

  // Size code 3 has no meaning on a 32-bit port; fold it onto a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] s);
    return (s == SIZE_WORD_ALT) ? SIZE_WORD : s;
  endfunction

endpackage

// File: rtl/sram_wstrb_gen.sv
// Purpose: byte-lane write strobe from access size and low address bits (32-bit bus).
// Ports: i_size (0 byte, 1 half, 2/3 word), i_addr_lo (addr[1:0]), o_wstrb (4 lanes).
// Latency: purely combinational; no backpressure involved.
module sram_wstrb_gen
  import sram_axi_responder_pkg::*;
(
  input  logic [1:0] i_size,
  input  logic [1:0] i_addr_lo,
  output logic [3:0] o_wstrb
);

  always_comb begin
    o_wstrb = 4'b1111;
    case (i_size)
      SIZE_BYTE: o_wstrb = 4'b0001 << i_addr_lo;
      // Halfwords only sit on lane pairs, so addr[0] is ignored.
      SIZE_HALF: o_wstrb = 4'b0011 << {i_addr_lo[1], 1'b0};
      default:   o_wstrb = 4'b1111;
    endcase
  end

endmodule

// File: rtl/sram_axi_responder.sv
// Purpose: serve one SRAM-like data request at a time as a single-beat AXI read or write.
// Ports: i_data_* request side with o_data_addr_ok/o_data_data_ok/o_data_rdata/o_bus_err;
//        AXI master channels AR, R, AW, W, B (single beat, INCR, constant ID).
// Latency: read with ready/valid immediate = 3 cycles addr_ok -> data_ok; one outstanding txn.
module sram_axi_responder
  import sram_axi_responder_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int AXI_ID = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  // request side
  input  logic              i_data_req,
  input  logic              i_data_wr,
  input  logic [1:0]        i_data_size,
  input  logic [ADDR_W-1:0] i_data_addr,
  input  logic [DATA_W-1:0] i_data_wdata,
  output logic [DATA_W-1:0] o_data_rdata,
  output logic              o_data_addr_ok,
  output logic              o_data_data_ok,
  output logic              o_bus_err,
  // AR
  output logic [3:0]        o_arid,
  output logic [ADDR_W-1:0] o_araddr,
  output logic [7:0]        o_arlen,
  output logic [2:0]        o_arsize,
  output logic [1:0]        o_arburst,
  output logic              o_arvalid,
  input  logic              i_arready,
  // R
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [1:0]        i_rresp,
  input  logic              i_rvalid,
  output logic              o_rready,
  // AW
  output logic [3:0]        o_awid,
  output logic [ADDR_W-1:0] o_awaddr,
  output logic [7:0]        o_awlen,
  output logic [2:0]        o_awsize,
  output logic [1:0]        o_awburst,
  output logic              o_awvalid,
  input  logic              i_awready,
  // W
  output logic [DATA_W-1:0] o_wdata,
  output logic [3:0]        o_wstrb,
  output logic              o_wlast,
  output logic              o_wvalid,
  input  logic              i_wready,
  // B
  input  logic [1:0]        i_bresp,
  input  logic              i_bvalid,
  output logic              o_bready
);

  localparam logic [3:0] ID_C = 4'(AXI_ID);

  state_t              r_state;
  state_t              w_next;
  logic                r_wr;
  logic [1:0]          r_size;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_aw_done;
  logic                r_w_done;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;

  logic                w_addr_ok;
  logic                w_data_ok;
  logic                w_arvalid;
  logic                w_rready;
  logic                w_awvalid;
  logic                w_wvalid;
  logic                w_bready;
  logic [3:0]          w_wstrb;

  sram_wstrb_gen u_wstrb (
    .i_size    (r_size),
    .i_addr_lo (r_addr[1:0]),
    .o_wstrb   (w_wstrb)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_wr      <= 1'b0;
      r_size    <= 2'd0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next;

      // The request is captured so the requester may move on after addr_ok.
      if (r_state == S_IDLE && i_data_req) begin
        r_wr    <= i_data_wr;
        r_size  <= norm_size(i_data_size);
        r_addr  <= i_data_addr;
        r_wdata <= i_data_wdata;
      end

      // AW and W complete independently; remember which one already went.
      if (r_state == S_WR_AW_W) begin
        if (w_awvalid && i_awready) r_aw_done <= 1'b1;
        if (w_wvalid && i_wready)   r_w_done  <= 1'b1;
      end else begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end

      if (r_state == S_RD_R && i_rvalid) begin
        r_rdata <= i_rdata;
        r_err   <= (i_rresp != RESP_OKAY);
      end else if (r_state == S_WR_B && i_bvalid) begin
        r_err   <= (i_bresp != RESP_OKAY);
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    w_addr_ok = 1'b0;
    w_data_ok = 1'b0;
    w_arvalid = 1'b0;
    w_rready  = 1'b0;
    w_awvalid = 1'b0;
    w_wvalid  = 1'b0;
    w_bready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_addr_ok = i_data_req;
        if (i_data_req) w_next = i_data_wr ? S_WR_AW_W : S_RD_AR;
      end
      S_RD_AR: begin
        w_arvalid = 1'b1;
        if (i_arready) w_next = S_RD_R;
      end
      S_RD_R: begin
        w_rready = 1'b1;
        if (i_rvalid) w_next = S_RESP;
      end
      S_WR_AW_W: begin
        w_awvalid = ~r_aw_done;
        w_wvalid  = ~r_w_done;
        // Either channel may finish now or earlier; both may finish together.
        if ((r_aw_done || i_awready) && (r_w_done || i_wready)) w_next = S_WR_B;
      end
      S_WR_B: begin
        w_bready = 1'b1;
        if (i_bvalid) w_next = S_RESP;
      end
      S_RESP: begin
        w_data_ok = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign o_data_addr_ok = w_addr_ok;
  assign o_data_data_ok = w_data_ok;
  assign o_data_rdata   = r_rdata;
  assign o_bus_err      = w_data_ok & r_err;

  assign o_arid    = ID_C;
  assign o_araddr  = r_addr;
  assign o_arlen   = LEN_SINGLE;
  assign o_arsize  = {1'b0, r_size};
  assign o_arburst = BURST_INCR;
  assign o_arvalid = w_arvalid;
  assign o_rready  = w_rready;

  assign o_awid    = ID_C;
  assign o_awaddr  = r_addr;
  assign o_awlen   = LEN_SINGLE;
  assign o_awsize  = {1'b0, r_size};
  assign o_awburst = BURST_INCR;
  assign o_awvalid = w_awvalid;
  assign o_wdata   = r_wdata;
  assign o_wstrb   = w_wstrb;
  assign o_wlast   = 1'b1;
  assign o_wvalid  = w_wvalid;
  assign o_bready  = w_bready;

endmodule

// File: tb/tb_sram_axi_responder.sv
// Bench for sram_axi_responder: directed transactions against a delay-configurable AXI slave.
// A transaction-level model checks every output on every cycle; literal checks pin key values.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_sram_axi_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        data_req = 1'b0, data_wr = 1'b0;
  logic [1:0]  data_size = 2'd0;
  logic [31:0] data_addr = '0, data_wdata = '0;
  logic [31:0] data_rdata;
  logic        data_addr_ok, data_data_ok, bus_err;
  logic [3:0]  arid, awid;
  logic [31:0] araddr, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;
  logic        arvalid, awvalid, wvalid, wlast, rready, bready;
  logic [3:0]  wstrb;
  logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = 2'b00, bresp = 2'b00;

  sram_axi_responder #(.ADDR_W(32), .DATA_W(32), .AXI_ID(0)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_data_req(data_req), .i_data_wr(data_wr), .i_data_size(data_size),
    .i_data_addr(data_addr), .i_data_wdata(data_wdata), .o_data_rdata(data_rdata),
    .o_data_addr_ok(data_addr_ok), .o_data_data_ok(data_data_ok), .o_bus_err(bus_err),
    .o_arid(arid), .o_araddr(araddr), .o_arlen(arlen), .o_arsize(arsize), .o_arburst(arburst),
    .o_arvalid(arvalid), .i_arready(arready),
    .i_rdata(rdata), .i_rresp(rresp), .i_rvalid(rvalid), .o_rready(rready),
    .o_awid(awid), .o_awaddr(awaddr), .o_awlen(awlen), .o_awsize(awsize), .o_awburst(awburst),
    .o_awvalid(awvalid), .i_awready(awready),
    .o_wdata(wdata), .o_wstrb(wstrb), .o_wlast(wlast), .o_wvalid(wvalid), .i_wready(wready),
    .i_bresp(bresp), .i_bvalid(bvalid), .o_bready(bready)
  );

  // AXI slave: each ready/valid answers after the configured number of waiting cycles.
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  int ar_w = 0, r_w = 0, aw_w = 0, w_w = 0, b_w = 0;
  always begin
    @(posedge clk); #1;
    arready = arvalid && (ar_w >= ar_dly); ar_w = arvalid ? ar_w + 1 : 0;
    rvalid  = rready  && (r_w  >= r_dly);  r_w  = rready  ? r_w  + 1 : 0;
    awready = awvalid && (aw_w >= aw_dly); aw_w = awvalid ? aw_w + 1 : 0;
    wready  = wvalid  && (w_w  >= w_dly);  w_w  = wvalid  ? w_w  + 1 : 0;
    bvalid  = bready  && (b_w  >= b_dly);  b_w  = bready  ? b_w  + 1 : 0;
  end

  int n_chk = 0, n_err = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model state.
  logic        m_busy = 0, m_wr = 0, m_ar = 0, m_r = 0, m_aw = 0, m_w = 0, m_b = 0;
  logic        m_due = 0, m_err = 0;
  logic [1:0]  m_size = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_rdata = 0;
  int          cyc_n = 0, acc_cyc = 0, done_cyc = 0, resp_cyc = 0, n_awv = 0, n_wv = 0;
  logic        accepted = 0, seen_done = 0, chk_zero = 0;
  logic [31:0] cap_rdata = 0, cap_araddr = 0;
  logic [2:0]  cap_arsize = 0, cap_awsize = 0;
  logic [3:0]  cap_wstrb = 0;
  logic        cap_err = 0, cap_wlast = 0;

  function automatic logic [3:0] exp_wstrb(input logic [1:0] sz, input logic [31:0] a);
    int nb, off, mask;
    nb   = 1 << sz;
    mask = (1 << nb) - 1;
    off  = int'(a[1:0]);
    off  = off - (off % nb);
    return 4'(mask << off);
  endfunction

  task automatic model_check();
    logic e_ar, e_r, e_aw, e_w, e_b;
    cyc_n++;
    if (rst) begin
      m_busy = 0; m_due = 0;
      return;
    end
    if (chk_zero) begin
      chk("rst_arvalid", 32'(arvalid), 0); chk("rst_rready", 32'(rready), 0);
      chk("rst_awvalid", 32'(awvalid), 0); chk("rst_wvalid", 32'(wvalid), 0);
      chk("rst_bready", 32'(bready), 0);   chk("rst_addr_ok", 32'(data_addr_ok), 0);
      chk("rst_data_ok", 32'(data_data_ok), 0); chk("rst_bus_err", 32'(bus_err), 0);
      chk("rst_rdata", data_rdata, 0);
      chk_zero = 0;
    end
    e_ar = m_busy && !m_due && !m_wr && !m_ar;
    e_r  = m_busy && !m_due && !m_wr && m_ar && !m_r;
    e_aw = m_busy && !m_due && m_wr && !m_aw;
    e_w  = m_busy && !m_due && m_wr && !m_w;
    e_b  = m_busy && !m_due && m_wr && m_aw && m_w && !m_b;

    chk("addr_ok", 32'(data_addr_ok), 32'(!m_busy && data_req));
    chk("data_ok", 32'(data_data_ok), 32'(m_due));
    if (m_due) begin
      if (!m_wr) chk("rdata", data_rdata, m_rdata);
      chk("bus_err", 32'(bus_err), 32'(m_err));
    end else chk("bus_err_idle", 32'(bus_err), 0);
    chk("arvalid", 32'(arvalid), 32'(e_ar));
    if (e_ar) begin
      chk("araddr", araddr, m_addr); chk("arsize", 32'(arsize), 32'(m_size));
      chk("arlen", 32'(arlen), 0);   chk("arburst", 32'(arburst), 1);
    end
    chk("rready", 32'(rready), 32'(e_r));
    chk("awvalid", 32'(awvalid), 32'(e_aw));
    if (e_aw) begin
      chk("awaddr", awaddr, m_addr); chk("awsize", 32'(awsize), 32'(m_size));
      chk("awlen", 32'(awlen), 0);   chk("awburst", 32'(awburst), 1);
    end
    chk("wvalid", 32'(wvalid), 32'(e_w));
    if (e_w) begin
      chk("wdata", wdata, m_wdata);
      chk("wstrb", 32'(wstrb), 32'(exp_wstrb(m_size, m_addr)));
      chk("wlast", 32'(wlast), 1);
    end
    chk("bready", 32'(bready), 32'(e_b));

    if (data_data_ok) begin seen_done = 1; done_cyc = cyc_n; cap_rdata = data_rdata; cap_err = bus_err; end
    if (arvalid) begin cap_araddr = araddr; cap_arsize = arsize; end
    if (awvalid) begin cap_awsize = awsize; n_awv++; end
    if (wvalid)  begin cap_wstrb = wstrb; cap_wlast = wlast; n_wv++; end

    if (m_due) begin
      m_due = 0; m_busy = 0;
    end else if (m_busy) begin
      if (e_ar && arready) m_ar = 1;
      if (e_r && rvalid) begin m_r = 1; m_due = 1; m_rdata = rdata; m_err = (rresp != 0); resp_cyc = cyc_n; end
      if (e_aw && awready) m_aw = 1;
      if (e_w && wready) m_w = 1;
      if (e_b && bvalid) begin m_b = 1; m_due = 1; m_err = (bresp != 0); resp_cyc = cyc_n; end
    end else if (data_req) begin
      m_busy = 1; m_wr = data_wr; m_addr = data_addr; m_wdata = data_wdata;
      m_size = (data_size == 2'd3) ? 2'd2 : data_size;
      {m_ar, m_r, m_aw, m_w, m_b} = '0;
      accepted = 1; acc_cyc = cyc_n; n_awv = 0; n_wv = 0;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    model_check();
    @(posedge clk); #1;
  endtask

  task automatic wait_accept();
    int n = 0;
    while (!accepted && n < 20) begin cyc(); n++; end
    if (!accepted) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!seen_done && n < 60) begin cyc(); n++; end
    if (!seen_done) chk("done_timeout", 0, 1);
  endtask

  task automatic run_txn(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    data_req = 1; data_wr = w; data_size = sz; data_addr = a; data_wdata = wd;
    accepted = 0; seen_done = 0;
    wait_accept();
    // Scramble the request lines: the transaction must run on latched values.
    data_req = 0; data_wr = ~w; data_size = ~sz; data_addr = ~a; data_wdata = ~wd;
    wait_done();
  endtask

  int acc1, d1;

  initial begin
    repeat (3) cyc();
    rst = 0; chk_zero = 1;
    cyc();

    // Word read, immediate slave.
    rdata = 32'hdeadbeef; rresp = 2'b00;
    run_txn(0, 2'd2, 32'h1fc0_0004, 32'h0);
    chk("t1_latency", 32'(done_cyc - acc_cyc), 3);
    chk("t1_rdata", cap_rdata, 32'hdeadbeef);
    chk("t1_araddr", cap_araddr, 32'h1fc00004);
    chk("t1_arsize", 32'(cap_arsize), 2);

    // Byte write to lane 3.
    run_txn(1, 2'd0, 32'h0000_0103, 32'hAB00_0000);
    chk("t2_wstrb", 32'(cap_wstrb), 32'h8);
    chk("t2_awsize", 32'(cap_awsize), 0);
    chk("t2_wlast", 32'(cap_wlast), 1);
    chk("t2_ok_after_b", 32'(done_cyc - resp_cyc), 1);

    // Write with AW held off for 4 cycles, W immediate.
    aw_dly = 4;
    run_txn(1, 2'd2, 32'h0000_0040, 32'h1234_5678);
    aw_dly = 0;
    chk("t3_wvalid_cycles", 32'(n_wv), 1);
    chk("t3_awvalid_cycles", 32'(n_awv), 5);
    chk("t3_latency", 32'(done_cyc - acc_cyc), 7);

    // Back-to-back reads with request held high; address changes after first accept.
    rdata = 32'h0bad_f00d;
    data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h0000_0200;
    accepted = 0; seen_done = 0;
    wait_accept();
    acc1 = acc_cyc;
    data_addr = 32'h0000_0300; accepted = 0;
    wait_done();
    d1 = done_cyc;
    chk("t4_first_rdata", cap_rdata, 32'h0badf00d);
    chk("t4_first_latency", 32'(d1 - acc1), 3);
    rdata = 32'h5555_aaaa;
    wait_accept();
    chk("t4_gap", 32'(acc_cyc - d1), 1);
    data_req = 0; seen_done = 0;
    wait_done();
    chk("t4_second_rdata", cap_rdata, 32'h5555aaaa);

    // Half write with SLVERR, then a clean read (size 3 handled as word).
    bresp = 2'b10;
    run_txn(1, 2'd1, 32'h0000_0002, 32'hBEEF_0000);
    chk("t5_wstrb", 32'(cap_wstrb), 32'hc);
    chk("t5_bus_err", 32'(cap_err), 1);
    bresp = 2'b00; rdata = 32'h0000_1111;
    run_txn(0, 2'd3, 32'h0000_0008, 32'h0);
    chk("t5_next_err", 32'(cap_err), 0);
    chk("t5_size3_arsize", 32'(cap_arsize), 2);

    // Reset while waiting for R.
    r_dly = 5;
    data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h0000_0400;
    accepted = 0; seen_done = 0;
    wait_accept();
    data_req = 0;
    repeat (2) cyc();
    chk("t6_in_rd_r", 32'(rready), 1);
    rst = 1;
    cyc();
    rst = 0; chk_zero = 1; r_dly = 0;
    repeat (4) cyc();
    chk("t6_no_done", 32'(seen_done), 0);
    rdata = 32'hcafe_0001;
    run_txn(0, 2'd2, 32'h0000_0404, 32'h0);
    chk("t6_after_rst_rdata", cap_rdata, 32'hcafe0001);
    chk("t6_after_rst_latency", 32'(done_cyc - acc_cyc), 3);

    repeat (2) cyc();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
